// File: rtl/pc_sequencer.sv
// Instruction fetch PC sequencer: drives a single-outstanding fetch request,
// steps the PC by 4 per delivered instruction, and applies taken-branch
// redirects either immediately or at the next handshake when a request is
// in flight.
module pc_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  output logic             imem_req,
  output logic [7:0]       imem_addr,
  input  logic             imem_ready,
  output logic             instr_valid,
  input  logic             br_valid,
  input  logic             branch,
  input  logic             zero,
  input  logic [7:0]       br_pc,
  input  logic [63:0]      immgen,
  output logic [7:0]       pc,
  output logic             redirect,
  output logic [CNT_W-1:0] fetch_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e           state_q;
  logic [7:0]       pc_q;
  logic [7:0]       pend_pc_q;
  logic             pend_q;
  logic             halt_pend_q;
  logic             req_q;
  logic             iv_q;
  logic             rd_q;
  logic [CNT_W-1:0] cnt_q;

  logic       taken;
  logic       hs;
  logic [7:0] target;
  logic [7:0] seq_pc;
  logic       unused_imm;

  // Branch resolution, target arithmetic and handshake detect.
  assign taken      = br_valid & branch & zero;
  assign target     = br_pc + {immgen[6:0], 1'b0};
  assign seq_pc     = pc_q + 8'd4;
  assign hs         = req_q & imem_ready;
  // Only the low immediate bits steer the target.
  assign unused_imm = ^immgen[63:7];

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_valid = iv_q;
  assign redirect    = rd_q;
  assign fetch_count = cnt_q;
  assign state       = state_q;

  // Fetch FSM with registered outputs; pending target holds a branch that
  // resolved while a request was stalled so the address stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      pend_pc_q   <= 8'h00;
      pend_q      <= 1'b0;
      halt_pend_q <= 1'b0;
      req_q       <= 1'b0;
      iv_q        <= 1'b0;
      rd_q        <= 1'b0;
      cnt_q       <= '0;
    end else begin
      iv_q <= 1'b0;
      rd_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (taken) begin
            pc_q <= target;
            rd_q <= 1'b1;
          end
          if (start) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
          end
        end
        S_REQ: begin
          if (hs) begin
            if (taken) begin
              pc_q   <= target;
              rd_q   <= 1'b1;
              pend_q <= 1'b0;
            end else if (pend_q) begin
              pc_q   <= pend_pc_q;
              rd_q   <= 1'b1;
              pend_q <= 1'b0;
            end else begin
              pc_q  <= seq_pc;
              iv_q  <= 1'b1;
              cnt_q <= cnt_q + CNT_W'(1);
            end
            if (halt || halt_pend_q) begin
              state_q     <= S_HALT;
              req_q       <= 1'b0;
              halt_pend_q <= 1'b0;
            end
          end else begin
            if (taken) begin
              pend_pc_q <= target;
              pend_q    <= 1'b1;
            end
            if (halt) halt_pend_q <= 1'b1;
          end
        end
        S_HALT: begin
          if (taken) begin
            pc_q <= target;
            rd_q <= 1'b1;
          end
          if (start && !halt) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_q       <= 1'b0;
          pend_q      <= 1'b0;
          halt_pend_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 8'h00: PC value loaded on reset.
REQ-002 Parameter CNT_W, default 16: width of the fetch counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin or resume fetching; sampled in IDLE and HALT only.
REQ-006 halt  input  1  stop fetching after any outstanding request completes.
REQ-007 imem_req  output  1  fetch request to instruction memory.
REQ-008 imem_addr  output  8  fetch address; equals pc.
REQ-009 imem_ready  input  1  memory accepts the request and returns the instruction; handshake = imem_req & imem_ready at an edge.
REQ-010 instr_valid  output  1  one-cycle pulse: the instruction from the last handshake is usable.
REQ-011 br_valid  input  1  a branch resolution is presented this cycle.
REQ-012 branch  input  1  resolved instruction is a branch.
REQ-013 zero  input  1  ALU zero flag of the resolved branch.
REQ-014 br_pc  input  8  PC of the resolved branch.
REQ-015 immgen  input  64  immediate of the resolved branch; only bits [6:0] are used.
REQ-016 pc  output  8  current program counter.
REQ-017 redirect  output  1  one-cycle pulse: a taken branch was applied to pc.
REQ-018 fetch_count  output  CNT_W  number of instructions delivered with instr_valid.
REQ-019 state  output  2  FSM state: IDLE=0, REQ=1, HALT=2.

Function
REQ-020 Taken branch = br_valid & branch & zero.
REQ-021 Target = br_pc + {immgen[6:0],1'b0}, modulo 256; immgen[63:7] has no effect.
REQ-022 Sequential next PC = pc + 4, modulo 256, so 8'hFC wraps to 8'h00.
REQ-023 IDLE: imem_req=0; start=1 -> REQ at the next edge; pc unchanged.
REQ-024 REQ: imem_req=1 continuously; imem_addr SHALL NOT change while a request is outstanding without a handshake.
REQ-025 Handshake with no pending redirect: pc <= pc+4; instr_valid=1 next cycle; fetch_count +1; back-to-back handshakes sustain one fetch per cycle.
REQ-026 Taken branch in IDLE, HALT, or REQ on a handshake edge: pc <= target at that edge; redirect=1 next cycle.
REQ-027 Taken branch on a handshake edge: the returned instruction is discarded (no instr_valid, no count increment).
REQ-028 Taken branch in REQ with no handshake at that edge: target latched as pending, pc held; at the next handshake pc <= pending target, the instruction is discarded, and redirect=1 next cycle.
REQ-029 A newer taken branch overwrites the pending target; redirect pulses once per applied redirect, not per branch.
REQ-030 halt=1 in REQ: at the next handshake edge -> HALT, with normal delivery or discard per REQ-025..028; imem_req=0 from the cycle after that edge.
REQ-031 HALT: imem_req=0; pc retained; start=1 -> REQ; halt and start together in HALT -> stay in HALT.
REQ-032 fetch_count wraps to 0 after all-ones.
REQ-033 Encodings 2'b11 of state are illegal; the FSM SHALL recover to IDLE.

Reset
REQ-034 rst_n=0 asynchronously forces state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, redirect=0, fetch_count=0, and clears any pending target.
REQ-035 Reset mid-request abandons the request; outputs take reset values immediately, with no wait for clk.
REQ-036 The first fetch after reset release requires start.

Verification
REQ-037 Reset, start, imem_ready held 1 -> imem_addr 00,04,08,0C on successive cycles; instr_valid held 1 from the second REQ cycle.
REQ-038 pc=FC, handshake -> pc=00, fetch_count increments, no error.
REQ-039 imem_ready=0 for 3 cycles, with a taken branch (br_pc=10, immgen[6:0]=7'h08) on cycle 1 -> imem_addr held; on the handshake pc=20, redirect pulses once, no instr_valid.
REQ-040 Taken branch with br_pc=F0, immgen[6:0]=7'h10 -> target 8'h10 (wrap); imm bits [63:7] toggled have no effect.
REQ-041 halt during a stalled request -> request completes, then HALT, imem_req=0; start -> fetch resumes from the retained pc.
REQ-042 rst_n low mid-request -> pc=RESET_PC and imem_req=0 before the next clk edge; pending target cleared.
